// File: rtl/mvm_rx_arbiter.sv
// ============================================================================
// mvm_rx_arbiter : packet-level round-robin arbiter feeding the MVM rx port
// Revision 1.0
// ============================================================================
`default_nettype none

module mvm_rx_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATAW     = 512,
  parameter int DESTW     = 12,
  parameter int USERW     = 75,
  parameter int PRIO_INST = 1,
  parameter int REQW      = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_tvalid,
  input  logic [NREQ*DATAW-1:0]  req_tdata,
  input  logic [NREQ*DESTW-1:0]  req_tdest,
  input  logic [NREQ*USERW-1:0]  req_tuser,
  input  logic [NREQ-1:0]        req_tlast,
  output logic [NREQ-1:0]        req_tready,
  output logic                   axis_rx_tvalid,
  output logic [DATAW-1:0]       axis_rx_tdata,
  output logic [DESTW-1:0]       axis_rx_tdest,
  output logic [USERW-1:0]       axis_rx_tuser,
  output logic                   axis_rx_tlast,
  input  logic                   axis_rx_tready,
  output logic                   grant_valid,
  output logic [REQW-1:0]        grant_id,
  output logic [15:0]            pkt_count
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [REQW:0]   c_NREQ = (REQW+1)'(NREQ);
  localparam logic [REQW-1:0] c_LAST = REQW'(NREQ-1);
  localparam logic [NREQ-1:0] c_ONE  = NREQ'(1);

  state_t            r_state;
  logic [REQW-1:0]   r_grant_id;
  logic [REQW-1:0]   r_last_grant;
  logic              r_grant_valid;
  logic [15:0]       r_pkt_count;
  logic              r_tvalid;
  logic              r_tlast;
  logic [DATAW-1:0]  r_tdata;
  logic [DESTW-1:0]  r_tdest;
  logic [USERW-1:0]  r_tuser;

  logic [DATAW-1:0]  w_data [NREQ];
  logic [DESTW-1:0]  w_dest [NREQ];
  logic [USERW-1:0]  w_user [NREQ];
  logic [NREQ-1:0]   w_inst;
  logic [NREQ-1:0]   w_cand;
  logic [REQW:0]     w_sum;
  logic [REQW-1:0]   w_winner;
  logic              w_found;
  logic              w_out_ready;
  logic              w_xfer;

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign w_data[i] = req_tdata[i*DATAW +: DATAW];
      assign w_dest[i] = req_tdest[i*DESTW +: DESTW];
      assign w_user[i] = req_tuser[i*USERW +: USERW];
      assign w_inst[i] = req_tvalid[i] && (req_tuser[i*USERW+9 +: 2] == 2'b00);
    end
  endgenerate

  assign w_cand = ((PRIO_INST != 0) && (|w_inst)) ? w_inst : req_tvalid;

  // Rotating scan starting just after the last granted requester
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_sum = {1'b0, r_last_grant} + (REQW+1)'(k);
      if (w_sum >= c_NREQ) w_sum = w_sum - c_NREQ;
      if (!w_found && w_cand[w_sum[REQW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[REQW-1:0];
      end
    end
  end

  assign w_out_ready = !r_tvalid || axis_rx_tready;
  assign w_xfer      = (r_state == BUSY) && w_out_ready && req_tvalid[r_grant_id];
  assign req_tready  = ((r_state == BUSY) && w_out_ready) ? (c_ONE << r_grant_id) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_grant_id    <= '0;
      r_last_grant  <= c_LAST;
      r_grant_valid <= 1'b0;
      r_pkt_count   <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_tdata       <= '0;
      r_tdest       <= '0;
      r_tuser       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_tvalid) begin
            r_grant_id    <= w_winner;
            r_grant_valid <= 1'b1;
            r_state       <= BUSY;
          end
        end
        BUSY: begin
          if (w_xfer && req_tlast[r_grant_id]) begin
            r_state       <= IDLE;
            r_last_grant  <= r_grant_id;
            r_grant_valid <= 1'b0;
            r_pkt_count   <= r_pkt_count + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Output register keeps draining the previous packet's last beat in IDLE
      if (w_xfer) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_data[r_grant_id];
        r_tdest  <= w_dest[r_grant_id];
        r_tuser  <= w_user[r_grant_id];
        r_tlast  <= req_tlast[r_grant_id];
      end else if (axis_rx_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign axis_rx_tvalid = r_tvalid;
  assign axis_rx_tdata  = r_tdata;
  assign axis_rx_tdest  = r_tdest;
  assign axis_rx_tuser  = r_tuser;
  assign axis_rx_tlast  = r_tlast;
  assign grant_valid    = r_grant_valid;
  assign grant_id       = r_grant_id;
  assign pkt_count      = r_pkt_count;

endmodule

`default_nettype wire

// File: tb/tb_mvm_rx_arbiter.sv
// ============================================================================
// tb_mvm_rx_arbiter : directed self-checking bench for mvm_rx_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mvm_rx_arbiter;

  localparam int NREQ  = 4;
  localparam int DATAW = 512;
  localparam int DESTW = 12;
  localparam int USERW = 75;
  localparam int REQW  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_tvalid;
  logic [NREQ*DATAW-1:0] req_tdata;
  logic [NREQ*DESTW-1:0] req_tdest;
  logic [NREQ*USERW-1:0] req_tuser;
  logic [NREQ-1:0]       req_tlast;
  logic [NREQ-1:0]       req_tready;
  logic                  axis_rx_tvalid;
  logic [DATAW-1:0]      axis_rx_tdata;
  logic [DESTW-1:0]      axis_rx_tdest;
  logic [USERW-1:0]      axis_rx_tuser;
  logic                  axis_rx_tlast;
  logic                  axis_rx_tready;
  logic                  grant_valid;
  logic [REQW-1:0]       grant_id;
  logic [15:0]           pkt_count;

  logic                  tv   [NREQ];
  logic [DATAW-1:0]      td   [NREQ];
  logic [DESTW-1:0]      tdst [NREQ];
  logic [USERW-1:0]      tu   [NREQ];
  logic                  tl   [NREQ];

  int checks   = 0;
  int failures = 0;

  logic [7:0] out_q [$];
  int         grant_q [$];
  logic       prev_gv = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    req_tvalid = '0;
    req_tdata  = '0;
    req_tdest  = '0;
    req_tuser  = '0;
    req_tlast  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_tvalid[i]                 = tv[i];
      req_tdata[i*DATAW +: DATAW]   = td[i];
      req_tdest[i*DESTW +: DESTW]   = tdst[i];
      req_tuser[i*USERW +: USERW]   = tu[i];
      req_tlast[i]                  = tl[i];
    end
  end

  mvm_rx_arbiter #(
    .NREQ(NREQ), .DATAW(DATAW), .DESTW(DESTW), .USERW(USERW), .PRIO_INST(1), .REQW(REQW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_tvalid(req_tvalid), .req_tdata(req_tdata), .req_tdest(req_tdest),
    .req_tuser(req_tuser), .req_tlast(req_tlast), .req_tready(req_tready),
    .axis_rx_tvalid(axis_rx_tvalid), .axis_rx_tdata(axis_rx_tdata),
    .axis_rx_tdest(axis_rx_tdest), .axis_rx_tuser(axis_rx_tuser),
    .axis_rx_tlast(axis_rx_tlast), .axis_rx_tready(axis_rx_tready),
    .grant_valid(grant_valid), .grant_id(grant_id), .pkt_count(pkt_count)
  );

  // Record accepted output beats and grant rising edges midway between edges
  always @(negedge clk) begin
    if (!rst && axis_rx_tvalid && axis_rx_tready) out_q.push_back(axis_rx_tdata[7:0]);
    if (!rst && grant_valid && !prev_gv) grant_q.push_back(int'(grant_id));
    prev_gv <= rst ? 1'b0 : grant_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    axis_rx_tready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      tv[i] = 1'b0; td[i] = '0; tdst[i] = '0; tu[i] = '0; tl[i] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;
    out_q.delete();
    grant_q.delete();
  endtask

  task automatic send_pkt(input int id, input int n, input logic [7:0] base,
                          input logic [1:0] op, input int gap_at, input int gap_len);
    for (int b = 0; b < n; b++) begin
      bit acc;
      int w;
      if (b == gap_at) begin
        tv[id] = 1'b0;
        repeat (gap_len) tick();
      end
      tv[id]   = 1'b1;
      td[id]   = {64{base + 8'(b)}};
      tu[id]   = USERW'({op, 9'(id)});
      tdst[id] = DESTW'(id + 5);
      tl[id]   = (b == n-1);
      acc = 1'b0;
      w   = 0;
      while (!acc && w < 200) begin
        @(negedge clk);
        acc = req_tready[id];
        tick();
        w++;
      end
      if (!acc) begin
        checks++;
        failures++;
        $display("FAIL send_pkt_timeout req%0d beat %0d: accepted=0 required=1", id, b);
        tv[id] = 1'b0;
        tl[id] = 1'b0;
        return;
      end
    end
    tv[id] = 1'b0;
    tl[id] = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (axis_rx_tvalid !== 1'b0 || axis_rx_tlast !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid_last: got %b/%b required 0/0", axis_rx_tvalid, axis_rx_tlast);
    end
    checks++;
    if (grant_valid !== 1'b0 || grant_id !== 2'd0 || pkt_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_grant: gv=%b id=%0d cnt=%0d required 0/0/0", grant_valid, grant_id, pkt_count);
    end
    checks++;
    if (req_tready !== 4'b0000 || axis_rx_tdata !== '0) begin
      failures++;
      $display("FAIL reset_ready_data: ready=%b data_lsb=%h required 0000/00", req_tready, axis_rx_tdata[7:0]);
    end
  endtask

  task automatic test_single();
    logic [USERW-1:0] exp_user;
    apply_reset();
    axis_rx_tready = 1'b1;
    exp_user = USERW'({2'd2, 9'h1A5});
    tv[1] = 1'b1; td[1] = {64{8'h01}}; tu[1] = exp_user; tdst[1] = 12'hABC; tl[1] = 1'b1;
    tick();
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd1 || axis_rx_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL single_grant: gv=%b id=%0d ov=%b required 1/1/0", grant_valid, grant_id, axis_rx_tvalid);
    end
    checks++;
    if (req_tready !== 4'b0010) begin
      failures++;
      $display("FAIL single_ready: got %b required 0010", req_tready);
    end
    tick();
    checks++;
    if (axis_rx_tvalid !== 1'b1 || axis_rx_tdata !== {64{8'h01}} || axis_rx_tlast !== 1'b1) begin
      failures++;
      $display("FAIL single_out: v=%b lsb=%h last=%b required 1/01/1", axis_rx_tvalid, axis_rx_tdata[7:0], axis_rx_tlast);
    end
    checks++;
    if (axis_rx_tuser !== exp_user || axis_rx_tdest !== 12'hABC) begin
      failures++;
      $display("FAIL single_user_dest: user=%h dest=%h required %h/abc", axis_rx_tuser, axis_rx_tdest, exp_user);
    end
    checks++;
    if (pkt_count !== 16'd1 || grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_count: cnt=%0d gv=%b required 1/0", pkt_count, grant_valid);
    end
    tv[1] = 1'b0;
    tl[1] = 1'b0;
    tick();
    checks++;
    if (axis_rx_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL single_drain: got %b required 0", axis_rx_tvalid);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    axis_rx_tready = 1'b1;
    fork
      begin send_pkt(0, 1, 8'h00, 2'd2, -1, 0); send_pkt(0, 1, 8'h01, 2'd2, -1, 0); end
      begin send_pkt(1, 1, 8'h10, 2'd2, -1, 0); send_pkt(1, 1, 8'h11, 2'd2, -1, 0); end
      begin send_pkt(2, 1, 8'h20, 2'd2, -1, 0); send_pkt(2, 1, 8'h21, 2'd2, -1, 0); end
      begin send_pkt(3, 1, 8'h30, 2'd2, -1, 0); send_pkt(3, 1, 8'h31, 2'd2, -1, 0); end
    join
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (grant_q.size() <= k || grant_q[k] != (k % 4)) begin
        failures++;
        $display("FAIL rr_grant[%0d]: got %0d required %0d", k,
                 (grant_q.size() > k) ? grant_q[k] : -1, k % 4);
      end
    end
    checks++;
    if (out_q.size() != 8 || out_q[4] !== 8'h01 || out_q[7] !== 8'h31) begin
      failures++;
      $display("FAIL rr_data: size=%0d required 8 with beats 01 at 4 and 31 at 7", out_q.size());
    end
    checks++;
    if (pkt_count !== 16'd8) begin
      failures++;
      $display("FAIL rr_count: got %0d required 8", pkt_count);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    axis_rx_tready = 1'b1;
    fork
      send_pkt(0, 1, 8'h0A, 2'd2, -1, 0);
      send_pkt(3, 1, 8'h3A, 2'd0, -1, 0);
    join
    tick();
    tick();
    checks++;
    if (grant_q.size() != 2 || grant_q[0] != 3 || grant_q[1] != 0) begin
      failures++;
      $display("FAIL prio_order: got size %0d first %0d required 2 entries 3,0", grant_q.size(),
               (grant_q.size() > 0) ? grant_q[0] : -1);
    end
    checks++;
    if (out_q.size() != 2 || out_q[0] !== 8'h3A || out_q[1] !== 8'h0A) begin
      failures++;
      $display("FAIL prio_data: size=%0d required beats 3a,0a", out_q.size());
    end
  endtask

  task automatic test_lock();
    logic [7:0] exp [4];
    exp = '{8'h21, 8'h22, 8'h23, 8'hA0};
    apply_reset();
    axis_rx_tready = 1'b1;
    fork
      send_pkt(2, 3, 8'h21, 2'd2, 2, 2);
      begin
        int w;
        w = 0;
        while (!grant_valid && w < 50) begin tick(); w++; end
        send_pkt(0, 1, 8'hA0, 2'd2, -1, 0);
      end
      begin
        // Mid-gap: req0 is valid but must not be served while req2 holds the grant
        repeat (4) tick();
        checks++;
        if (grant_id !== 2'd2 || grant_valid !== 1'b1 || req_tready[0] !== 1'b0) begin
          failures++;
          $display("FAIL lock_hold: id=%0d gv=%b rdy0=%b required 2/1/0", grant_id, grant_valid, req_tready[0]);
        end
      end
    join
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_q.size() <= k || out_q[k] !== exp[k]) begin
        failures++;
        $display("FAIL lock_beat[%0d]: got %h required %h", k,
                 (out_q.size() > k) ? out_q[k] : 8'h00, exp[k]);
      end
    end
    checks++;
    if (grant_q.size() != 2 || grant_q[0] != 2 || grant_q[1] != 0) begin
      failures++;
      $display("FAIL lock_grants: size=%0d required grants 2,0", grant_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [DATAW-1:0] snap;
    apply_reset();
    axis_rx_tready = 1'b1;
    fork
      send_pkt(1, 4, 8'h11, 2'd2, -1, 0);
      begin
        int w;
        w = 0;
        while (!axis_rx_tvalid && w < 50) begin tick(); w++; end
        axis_rx_tready = 1'b0;
        snap = axis_rx_tdata;
        for (int c = 0; c < 5; c++) begin
          tick();
          checks++;
          if (axis_rx_tdata !== snap || axis_rx_tvalid !== 1'b1 || req_tready[1] !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall[%0d]: lsb=%h v=%b rdy=%b required %h/1/0", c,
                     axis_rx_tdata[7:0], axis_rx_tvalid, req_tready[1], snap[7:0]);
          end
        end
        axis_rx_tready = 1'b1;
      end
    join
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_q.size() <= k || out_q[k] !== 8'(8'h11 + k)) begin
        failures++;
        $display("FAIL bp_beat[%0d]: got %h required %h", k,
                 (out_q.size() > k) ? out_q[k] : 8'h00, 8'(8'h11 + k));
      end
    end
    checks++;
    if (out_q.size() != 4 || pkt_count !== 16'd1) begin
      failures++;
      $display("FAIL bp_count: beats=%0d cnt=%0d required 4/1", out_q.size(), pkt_count);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    axis_rx_tready = 1'b1;
    tv[0] = 1'b1; td[0] = {64{8'h31}}; tu[0] = USERW'({2'd2, 9'd0}); tdst[0] = 12'd5; tl[0] = 1'b0;
    tick();
    tick();
    td[0] = {64{8'h32}};
    checks++;
    if (axis_rx_tvalid !== 1'b1 || axis_rx_tdata[7:0] !== 8'h31) begin
      failures++;
      $display("FAIL rstmid_first: v=%b lsb=%h required 1/31", axis_rx_tvalid, axis_rx_tdata[7:0]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tv[0] = 1'b0;
    checks++;
    if (axis_rx_tvalid !== 1'b0 || grant_valid !== 1'b0 || pkt_count !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_clear: v=%b gv=%b cnt=%0d required 0/0/0", axis_rx_tvalid, grant_valid, pkt_count);
    end
    out_q.delete();
    grant_q.delete();
    send_pkt(0, 4, 8'h31, 2'd2, -1, 0);
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_q.size() <= k || out_q[k] !== 8'(8'h31 + k)) begin
        failures++;
        $display("FAIL rstmid_beat[%0d]: got %h required %h", k,
                 (out_q.size() > k) ? out_q[k] : 8'h00, 8'(8'h31 + k));
      end
    end
    checks++;
    if (pkt_count !== 16'd1) begin
      failures++;
      $display("FAIL rstmid_count: got %0d required 1", pkt_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_lock();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
